uart_get: RTL

//  Standalone 8N1 UART receiver, the receive-side counterpart of uart_put. Turns the serial input

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_get.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period and receiver FSM state encoding.
package uart_pkg;
  localparam int CLKS_PER_BAUD_DEF = 104;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial input; resets to RESET_VAL.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/uart_get.sv
// 8N1 UART receiver with start-glitch rejection, framing/overrun flags and a
// one-byte holding register read through a valid/take handshake.
module uart_get
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = CLKS_PER_BAUD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart,
  input  logic        take,
  output logic [7:0]  x,
  output logic        valid,
  output logic        frame_err,
  output logic        overrun,
  output uart_state_t dbg_state
);
  localparam int HALF_BAUD = CLKS_PER_BAUD / 2;
  localparam int CW        = $clog2(CLKS_PER_BAUD);

  // Handshake: x is meaningful while valid=1; a cycle with valid & take consumes it.
  // A delivery in the same cycle as a take refills the register without overrun.
  uart_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitn;
  logic [7:0]    r_shift;
  logic [7:0]    r_x;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_rx_s;
  logic          w_tick;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (uart),
    .o_q (w_rx_s)
  );

  assign w_tick = (r_cnt == '0) && (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_shift     <= '0;
      r_x         <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (take && r_valid) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= CW'(HALF_BAUD - 1);
          end
        end
        START: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_state <= DATA;
              r_bitn  <= '0;
              r_cnt   <= CW'(CLKS_PER_BAUD - 1);
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift[r_bitn] <= w_rx_s;
            r_cnt           <= CW'(CLKS_PER_BAUD - 1);
            if (r_bitn == 3'd7) r_state <= STOP;
            else                r_bitn  <= r_bitn + 3'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (w_rx_s) begin
              r_state <= IDLE;
              if (!r_valid || take) begin
                r_x     <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // A held-low line parks here so it cannot be mistaken for new start bits.
        BREAK: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x         = r_x;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;
endmodule
